seq_serial_rx: RTL and testbench

- Single-bit serial frame receiver. It samples a one-bit-per-clock serial line `d`, detects a start bit, and shifts in WIDTH data bits LSB-first.
- It checks the stop bit, then presents the assembled word on a one-entry valid/ready output buffer.
- It is the receive end of the single-bit sequential `d` → `q` register path used across the sequential-statement benchmarks. It exercises always_ff with async reset, case-based FSM, counters and shift registers.

---
 rtl/seq_serial_rx.sv | 116 +++++++++++
 tb/tb_seq_serial_rx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_serial_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, one stop bit.
// A received word is held in a one-entry valid/ready buffer until consumed.
// frame_err and overrun are single-cycle pulses reporting bad stop bits and
// good frames lost because the buffer was still full.
module seq_serial_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             busy_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             consume;

    // Right shift with the incoming bit entering at the MSB, so the first
    // data bit ends up in bit 0 once all WIDTH bits have arrived.
    always_comb begin
        shift_d            = shift_q >> 1;
        shift_d[WIDTH-1]   = d;
    end

    assign consume = valid_q && ready;

    // Receive FSM, bit counter, shift register and output buffer; the
    // buffer's consume is applied first so a same-edge commit overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (consume) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (!d) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                DATA: begin
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (d) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (!valid_q || ready) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= BREAK;
                    end
                end
                BREAK: begin
                    if (d) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seq_serial_rx.sv
// Bench for seq_serial_rx: frames are generated at the word level, a
// frame-level buffer model predicts commits, overruns and frame errors into
// queues, and a negedge monitor pops and compares whatever the DUT presents.
module tb_seq_serial_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         d;
    logic         ready;
    logic [W-1:0] data;
    logic         valid;
    logic         busy;
    logic         frameErr;
    logic         overrun;

    logic         d1;
    logic         ready1;
    logic [0:0]   data1;
    logic         valid1;
    logic         busy1;
    logic         frameErr1;
    logic         overrun1;

    int checks = 0;
    int errors = 0;
    int edgeNum = 0;

    // Frame-level model of the output buffer
    logic         mValid = 1'b0;
    logic [W-1:0] mData = '0;

    typedef struct {
        logic [W-1:0] word;
        int           edgeN;
    } wordEv_t;

    wordEv_t wordQ[$];
    int      errQ[$];
    int      ovrQ[$];

    logic pValid = 1'b0;
    logic pReady = 1'b0;
    bit   monOn = 1'b0;

    seq_serial_rx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frameErr),
        .overrun   (overrun)
    );

    seq_serial_rx #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d1),
        .data      (data1),
        .valid     (valid1),
        .ready     (ready1),
        .busy      (busy1),
        .frame_err (frameErr1),
        .overrun   (overrun1)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, edgeNum);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: DUT pulsed/presented at edge %0d but nothing expected", name, edgeNum);
    endtask

    // One clock: drive inputs, take the edge, then advance the buffer model.
    // ev: 0 plain bit, 1 good stop bit carrying w, 2 bad stop bit.
    task automatic applyStimulus(input logic dVal, input logic rdy, input int ev, input logic [W-1:0] w);
        logic consumed;
        d     = dVal;
        ready = rdy;
        @(posedge clk);
        #1;
        edgeNum++;
        if (!rst_n) begin
            mValid = 1'b0;
            mData  = '0;
        end else begin
            consumed = mValid && rdy;
            if (ev == 1) begin
                if (!mValid || rdy) begin
                    mValid = 1'b1;
                    mData  = w;
                    wordQ.push_back('{w, edgeNum});
                end else begin
                    ovrQ.push_back(edgeNum);
                end
            end else begin
                if (consumed) mValid = 1'b0;
                if (ev == 2) errQ.push_back(edgeNum);
            end
        end
    endtask

    // mode: 0 ready low, 1 ready high, 2 random, 3 high only on the stop bit
    function automatic logic pickReady(input int mode, input bit isStop);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return logic'($urandom_range(0, 1));
            default: return isStop;
        endcase
    endfunction

    task automatic sendFrame(input logic [W-1:0] word, input logic stopBit, input int gap, input int mode);
        for (int i = 0; i < gap; i++) applyStimulus(1'b1, pickReady(mode, 1'b0), 0, '0);
        applyStimulus(1'b0, pickReady(mode, 1'b0), 0, '0);
        for (int i = 0; i < W; i++) applyStimulus(word[i], pickReady(mode, 1'b0), 0, '0);
        applyStimulus(stopBit, pickReady(mode, 1'b1), stopBit ? 1 : 2, word);
    endtask

    // Monitor: compare buffer state with the model every cycle and pop the
    // scoreboard whenever a new word, frame error or overrun is presented.
    always @(negedge clk) begin
        if (monOn) begin
            if (!rst_n) begin
                pValid = 1'b0;
                pReady = 1'b0;
            end else begin
                checkOutput("validVsModel", valid, mValid);
                checkOutput("dataVsModel", data, mData);
                if (valid && (!pValid || pReady)) begin
                    if (wordQ.size() == 0) unexpected("wordPresented");
                    else begin
                        wordEv_t e;
                        e = wordQ.pop_front();
                        checkOutput("wordData", data, e.word);
                        checkOutput("wordEdge", edgeNum, e.edgeN);
                    end
                end
                if (frameErr) begin
                    if (errQ.size() == 0) unexpected("frameErrPulse");
                    else checkOutput("frameErrEdge", edgeNum, errQ.pop_front());
                end
                if (overrun) begin
                    if (ovrQ.size() == 0) unexpected("overrunPulse");
                    else checkOutput("overrunEdge", edgeNum, ovrQ.pop_front());
                end
                pValid = valid;
                pReady = ready;
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        d      = 1'b1;
        ready  = 1'b0;
        d1     = 1'b1;
        ready1 = 1'b1;
        #12;
        checkOutput("resetData", data, 0);
        checkOutput("resetValid", valid, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetFrameErr", frameErr, 0);
        checkOutput("resetOverrun", overrun, 0);
        rst_n = 1'b1;
        monOn = 1'b1;
        repeat (3) applyStimulus(1'b1, 1'b1, 0, '0);

        // Single frame 0xA5 with ready high: valid for exactly one cycle
        sendFrame(8'hA5, 1'b1, 1, 1);
        checkOutput("a5Valid", valid, 1);
        checkOutput("a5Data", data, 8'hA5);
        applyStimulus(1'b1, 1'b1, 0, '0);
        checkOutput("a5ValidDrop", valid, 0);

        // Two back-to-back frames with ready low: second one overruns
        sendFrame(8'h3C, 1'b1, 2, 0);
        sendFrame(8'hFF, 1'b1, 0, 0);
        checkOutput("ovrData", data, 8'h3C);
        checkOutput("ovrPulse", overrun, 1);
        applyStimulus(1'b1, 1'b1, 0, '0);
        checkOutput("ovrValidDrop", valid, 0);

        // Bad stop bit, line held low, then a good frame
        sendFrame(8'h81, 1'b0, 1, 1);
        checkOutput("breakBusyStop", busy, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 0, '0);
            checkOutput("breakBusyLow", busy, 1);
        end
        applyStimulus(1'b1, 1'b1, 0, '0);
        checkOutput("breakIdle", busy, 0);
        sendFrame(8'h12, 1'b1, 0, 1);
        checkOutput("after12Data", data, 8'h12);
        checkOutput("after12Valid", valid, 1);

        // Commit coincides with consume: valid stays high, data swaps
        applyStimulus(1'b1, 1'b1, 0, '0);
        sendFrame(8'h55, 1'b1, 1, 0);
        sendFrame(8'hAA, 1'b1, 0, 3);
        checkOutput("swapValid", valid, 1);
        checkOutput("swapData", data, 8'hAA);
        checkOutput("swapNoOverrun", overrun, 0);
        applyStimulus(1'b1, 1'b1, 0, '0);

        // Randomized frames, ready patterns and occasional bad stop bits
        for (int n = 0; n < 60; n++) begin
            logic [W-1:0] w;
            int mode;
            int gap;
            w    = W'($urandom);
            mode = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 2));
            gap  = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                sendFrame(w, 1'b0, gap, mode);
                repeat ($urandom_range(0, 3)) applyStimulus(1'b0, pickReady(mode, 1'b0), 0, '0);
                applyStimulus(1'b1, pickReady(mode, 1'b0), 0, '0);
            end else begin
                sendFrame(w, 1'b1, gap, mode);
            end
        end

        // Asynchronous reset in the middle of data bit 4
        repeat (2) applyStimulus(1'b1, 1'b1, 0, '0);
        sendFrame(8'hC3, 1'b1, 1, 0);
        applyStimulus(1'b1, 1'b0, 0, '0);
        applyStimulus(1'b0, 1'b0, 0, '0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 0, '0);
        #2;
        rst_n  = 1'b0;
        mValid = 1'b0;
        mData  = '0;
        #1;
        checkOutput("asyncData", data, 0);
        checkOutput("asyncValid", valid, 0);
        checkOutput("asyncBusy", busy, 0);
        checkOutput("asyncFrameErr", frameErr, 0);
        checkOutput("asyncOverrun", overrun, 0);
        applyStimulus(1'b1, 1'b0, 0, '0);
        rst_n = 1'b1;
        sendFrame(8'h0F, 1'b1, 1, 1);
        checkOutput("postResetData", data, 8'h0F);
        checkOutput("postResetValid", valid, 1);

        // WIDTH=1 receiver: frames 0,1,1 and 0,0,1
        repeat (2) applyStimulus(1'b1, 1'b1, 0, '0);
        d1 = 1'b0; applyStimulus(1'b1, 1'b1, 0, '0);
        d1 = 1'b1; applyStimulus(1'b1, 1'b1, 0, '0);
        checkOutput("w1EarlyValid", valid1, 0);
        d1 = 1'b1; applyStimulus(1'b1, 1'b1, 0, '0);
        checkOutput("w1ValidA", valid1, 1);
        checkOutput("w1DataA", data1, 1);
        d1 = 1'b0; applyStimulus(1'b1, 1'b1, 0, '0);
        d1 = 1'b0; applyStimulus(1'b1, 1'b1, 0, '0);
        d1 = 1'b1; applyStimulus(1'b1, 1'b1, 0, '0);
        checkOutput("w1ValidB", valid1, 1);
        checkOutput("w1DataB", data1, 0);
        checkOutput("w1NoErr", frameErr1, 0);
        checkOutput("w1NoOvr", overrun1, 0);
        applyStimulus(1'b1, 1'b1, 0, '0);
        checkOutput("w1ValidDrop", valid1, 0);

        // Drain and confirm every predicted event was observed
        repeat (4) applyStimulus(1'b1, 1'b1, 0, '0);
        #6;
        checkOutput("wordQEmpty", wordQ.size(), 0);
        checkOutput("errQEmpty", errQ.size(), 0);
        checkOutput("ovrQEmpty", ovrQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
